bht_ctrl: RTL and testbench



---
 rtl/bht_pkg.sv | 29 ++
 rtl/bht_sat_counter.sv | 25 ++
 rtl/bht_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bht_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// -----------------------------------------------------------------------------
// bht_pkg -- shared types and constants for the branch history table controller.
//
// Contents:
//   bht_state_e : controller FSM states (INIT, IDLE, PRED_RSP, UPD_WR)
//   grant_e     : round-robin grant owner (PRED, UPD)
//   CTR_*       : 2-bit saturating counter encodings
// -----------------------------------------------------------------------------
package bht_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    PRED_RSP = 2'd2,
    UPD_WR   = 2'd3
  } bht_state_e;

  typedef enum logic {
    PRED = 1'b0,
    UPD  = 1'b1
  } grant_e;

  // Counter encoding; the prediction is bit 1.
  localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

endpackage

// File: rtl/bht_sat_counter.sv
// -----------------------------------------------------------------------------
// bht_sat_counter -- combinational 2-bit saturating counter next-state.
//
// Ports:
//   state_i : current counter value
//   taken_i : resolved direction (1 = count up, 0 = count down)
//   next_o  : saturated next counter value
// -----------------------------------------------------------------------------
module bht_sat_counter
  import bht_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    if (taken_i) begin
      next_o = (state_i == CTR_ST) ? CTR_ST : state_i + 2'd1;
    end else begin
      next_o = (state_i == CTR_SNT) ? CTR_SNT : state_i - 2'd1;
    end
  end

endmodule

// File: rtl/bht_ctrl.sv
// -----------------------------------------------------------------------------
// bht_ctrl -- controller/arbiter for the single-port 2-bit branch history table.
//
// Shares one table port between the fetch-side lookup and the resolve-side
// update, performing the update as a read followed by a write of the
// saturated counter. Requests are fully serialized (one accept every two
// cycles at most), so a lookup after an update always sees the new value.
//
// Configuration macro:
//   BHT_CTRL_INIT_EN : when defined, reset enters a sweep that writes
//                      INIT_STATE to every entry before init_done rises.
//                      When undefined, reset goes straight to IDLE and
//                      init_done rises on the first clock after release.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   pred_valid/addr : lookup request;        pred_ready accepts it
//   pred_rsp_valid  : one-cycle response pulse with pred_taken / pred_state
//   upd_valid/addr/taken : update request;   upd_ready accepts it
//   mem_addr/wr/wdata    : table port; mem_rdata valid one cycle after a read
//   init_done       : table usable (registered)
// -----------------------------------------------------------------------------
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int         ADDR_W     = 10,
  parameter logic [1:0] INIT_STATE = CTR_SNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [ADDR_W-1:0] pred_addr,
  output logic              pred_ready,
  output logic              pred_rsp_valid,
  output logic              pred_taken,
  output logic [1:0]        pred_state,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata,
  output logic              init_done
);

`ifdef BHT_CTRL_INIT_EN
  localparam bht_state_e RESET_STATE = INIT;
`else
  localparam bht_state_e RESET_STATE = IDLE;
`endif

  bht_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
  logic              upd_taken_q, upd_taken_d;
  logic              init_done_q, init_done_d;
  logic              grant_upd;
  logic [1:0]        sat_next;

`ifdef BHT_CTRL_INIT_EN
  logic [ADDR_W-1:0] init_idx_q, init_idx_d;
`else
  // INIT_STATE has no role without the sweep.
  logic unused_init_state;
  assign unused_init_state = ^INIT_STATE;
`endif

  bht_sat_counter u_sat (
    .state_i (mem_rdata),
    .taken_i (upd_taken_q),
    .next_o  (sat_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      last_grant_q <= PRED;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      init_done_q  <= 1'b0;
`ifdef BHT_CTRL_INIT_EN
      init_idx_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      upd_addr_q   <= upd_addr_d;
      upd_taken_q  <= upd_taken_d;
      init_done_q  <= init_done_d;
`ifdef BHT_CTRL_INIT_EN
      init_idx_q   <= init_idx_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skipped an assignment would otherwise infer a latch.
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    upd_addr_d     = upd_addr_q;
    upd_taken_d    = upd_taken_q;
`ifdef BHT_CTRL_INIT_EN
    init_idx_d     = init_idx_q;
    init_done_d    = init_done_q;
`else
    init_done_d    = 1'b1;
`endif
    grant_upd      = 1'b0;
    pred_ready     = 1'b0;
    upd_ready      = 1'b0;
    pred_rsp_valid = 1'b0;
    pred_taken     = 1'b0;
    pred_state     = CTR_SNT;
    mem_addr       = '0;
    mem_wr         = 1'b0;
    mem_wdata      = CTR_SNT;

    unique case (state_q)
`ifdef BHT_CTRL_INIT_EN
      INIT: begin
        mem_wr     = 1'b1;
        mem_addr   = init_idx_q;
        mem_wdata  = INIT_STATE;
        init_idx_d = init_idx_q + ADDR_W'(1);
        if (init_idx_q == '1) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
`endif
      IDLE: begin
        // On a tie the requester that did not win last time is granted.
        grant_upd = upd_valid && (!pred_valid || last_grant_q == PRED);
        if (grant_upd) begin
          upd_ready    = 1'b1;
          mem_addr     = upd_addr;
          upd_addr_d   = upd_addr;
          upd_taken_d  = upd_taken;
          last_grant_d = UPD;
          state_d      = UPD_WR;
        end else if (pred_valid) begin
          pred_ready   = 1'b1;
          mem_addr     = pred_addr;
          last_grant_d = PRED;
          state_d      = PRED_RSP;
        end
      end
      PRED_RSP: begin
        pred_rsp_valid = 1'b1;
        pred_state     = mem_rdata;
        pred_taken     = mem_rdata[1];
        state_d        = IDLE;
      end
      UPD_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = upd_addr_q;
        mem_wdata = sat_next;
        state_d   = IDLE;
      end
      default: state_d = RESET_STATE;
    endcase

    // The state register already holds its reset value while rst is high,
    // but the outputs decoded from it (sweep write, IDLE readies) must stay
    // quiet until release, and a write in flight must drop immediately.
    if (rst) begin
      pred_ready     = 1'b0;
      upd_ready      = 1'b0;
      pred_rsp_valid = 1'b0;
      pred_taken     = 1'b0;
      pred_state     = CTR_SNT;
      mem_addr       = '0;
      mem_wr         = 1'b0;
      mem_wdata      = CTR_SNT;
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_bht_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bht_ctrl -- self-checking bench for bht_ctrl (ADDR_W = 4).
// Includes a behavioural model of the table storage and a reference table of
// counter values; works with or without BHT_CTRL_INIT_EN defined.
// -----------------------------------------------------------------------------
module tb_bht_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          pred_valid;
  logic [AW-1:0] pred_addr;
  logic          pred_ready;
  logic          pred_rsp_valid;
  logic          pred_taken;
  logic [1:0]    pred_state;
  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic          upd_taken;
  logic          upd_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [1:0]    mem_wdata;
  logic [1:0]    mem_rdata;
  logic          init_done;

  bht_ctrl #(.ADDR_W(AW), .INIT_STATE(2'b00)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_valid     (pred_valid),
    .pred_addr      (pred_addr),
    .pred_ready     (pred_ready),
    .pred_rsp_valid (pred_rsp_valid),
    .pred_taken     (pred_taken),
    .pred_state     (pred_state),
    .upd_valid      (upd_valid),
    .upd_addr       (upd_addr),
    .upd_taken      (upd_taken),
    .upd_ready      (upd_ready),
    .mem_addr       (mem_addr),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .init_done      (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table storage: synchronous write, read data valid the cycle after.
  logic [1:0] mem [DEPTH];
  logic       bench_fill;
  logic [1:0] bench_fill_val;

  always @(posedge clk) begin
    if (bench_fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= bench_fill_val;
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int ref_tbl [DEPTH];

  typedef struct {
    bit is_upd;
    int addr;
    bit taken;
    int exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Counter rule: move one step toward the resolved direction, clamp at 0..3.
  function automatic int sat(input int v, input bit t);
    if (t) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Called just after a rising edge with the controller in IDLE.
  task automatic do_lookup(input int addr, input int exp, input string name);
    int n = 0;
    pred_valid = 1'b1;
    pred_addr  = AW'(addr);
    upd_valid  = 1'b0;
    sample();
    while (!pred_ready && n < 8) begin
      tick();
      sample();
      n++;
    end
    check({name, "_ready"}, pred_ready, 1);
    check({name, "_addr"}, mem_addr, addr);
    tick();
    pred_valid = 1'b0;
    sample();
    check({name, "_rsp_valid"}, pred_rsp_valid, 1);
    check({name, "_state"}, pred_state, exp);
    check({name, "_taken"}, pred_taken, (exp >= 2) ? 1 : 0);
    tick();
  endtask

  task automatic do_update(input int addr, input bit taken, input int exp, input string name);
    int n = 0;
    upd_valid  = 1'b1;
    upd_addr   = AW'(addr);
    upd_taken  = taken;
    pred_valid = 1'b0;
    sample();
    while (!upd_ready && n < 8) begin
      tick();
      sample();
      n++;
    end
    check({name, "_ready"}, upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    sample();
    check({name, "_wr"}, mem_wr, 1);
    check({name, "_waddr"}, mem_addr, addr);
    check({name, "_wdata"}, mem_wdata, exp);
    check({name, "_no_ready"}, {pred_ready, upd_ready}, 0);
    ref_tbl[addr] = exp;
    tick();
  endtask

  // Asserts reset with both requests raised, checks quiet outputs, releases.
  task automatic do_reset();
    rst        = 1'b1;
    pred_valid = 1'b1;
    upd_valid  = 1'b1;
    upd_addr   = 4'd3;
    pred_addr  = 4'd9;
    sample();
    check("rst_outputs",
          {pred_ready, upd_ready, pred_rsp_valid, pred_taken, pred_state,
           mem_wr, mem_wdata, mem_addr}, 0);
    check("rst_init_done", init_done, 0);
    tick();
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    rst        = 1'b0;
  endtask

`ifdef BHT_CTRL_INIT_EN
  // Starts right after reset release; requests stay raised to show no grant.
  task automatic run_sweep();
    int nonzero = 0;
    pred_valid = 1'b1;
    upd_valid  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sample();
      check("sweep_wr", mem_wr, 1);
      check("sweep_addr", mem_addr, i);
      check("sweep_wdata", mem_wdata, 0);
      check("sweep_no_ready", {pred_ready, upd_ready}, 0);
      check("sweep_init_done", init_done, 0);
      if (i == DEPTH - 1) begin
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
      end
      tick();
    end
    sample();
    check("sweep_done", init_done, 1);
    check("sweep_end_wr", mem_wr, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] != 2'b00) nonzero++;
      ref_tbl[i] = 0;
    end
    check("sweep_table_clear", nonzero, 0);
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy, m_addr, m_last, exp;
    bit m_taken, pv, uv, ut, eg_p, eg_u;
    int pa, ua;

    vecs[0] = '{1'b1, 5, 1'b1, 1};
    vecs[1] = '{1'b1, 5, 1'b1, 2};
    vecs[2] = '{1'b1, 5, 1'b1, 3};
    vecs[3] = '{1'b1, 5, 1'b1, 3};
    vecs[4] = '{1'b1, 5, 1'b0, 2};
    vecs[5] = '{1'b0, 5, 1'b0, 2};
    vecs[6] = '{1'b1, 0, 1'b0, 0};
    vecs[7] = '{1'b0, 0, 1'b0, 0};
    vecs[8] = '{1'b0, 7, 1'b0, 2};

    rst        = 1'b1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    pred_addr  = '0;
    upd_addr   = '0;
    upd_taken  = 1'b0;
    bench_fill = 1'b1;
`ifdef BHT_CTRL_INIT_EN
    bench_fill_val = 2'b11;  // stale contents the sweep must overwrite
`else
    bench_fill_val = 2'b00;  // cleared externally
`endif
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 0;
    tick();
    tick();
    bench_fill = 1'b0;

    // Reset and start-up.
    do_reset();
`ifdef BHT_CTRL_INIT_EN
    run_sweep();
`else
    sample();
    check("start_init_done_low", init_done, 0);
    tick();
    sample();
    check("start_init_done_high", init_done, 1);
    tick();
`endif
    do_lookup(5, 0, "first_lookup");

    // Both requesters held: upd, pred, upd, pred with a gap cycle each.
    pred_valid = 1'b1;
    pred_addr  = 4'd7;
    upd_valid  = 1'b1;
    upd_addr   = 4'd7;
    upd_taken  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      case (k % 4)
        0: check("alt_upd_grant", {upd_ready, pred_ready}, 2'b10);
        1: begin
          check("alt_gap1", {upd_ready, pred_ready}, 0);
          ref_tbl[7] = sat(ref_tbl[7], 1'b1);
          check("alt_wdata", {mem_wr, mem_wdata}, {1'b1, 2'(ref_tbl[7])});
        end
        2: check("alt_pred_grant", {upd_ready, pred_ready}, 2'b01);
        default: begin
          check("alt_gap2", {upd_ready, pred_ready}, 0);
          check("alt_rsp", {pred_rsp_valid, pred_state}, {1'b1, 2'(ref_tbl[7])});
        end
      endcase
      if (k == 7) begin
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
      end
      tick();
    end

    // Saturating counter sequences from a table.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_upd) do_update(vecs[i].addr, vecs[i].taken, vecs[i].exp, $sformatf("vec%0d", i));
      else do_lookup(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset while an update's write is pending: the write is lost.
    upd_valid = 1'b1;
    upd_addr  = 4'd3;
    upd_taken = 1'b1;
    sample();
    check("rstwr_ready", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    sample();
    check("rstwr_wr_before", mem_wr, 1);
    rst = 1'b1;
    #1;
    check("rstwr_wr_dropped", mem_wr, 0);
    check("rstwr_init_done_cleared", init_done, 0);
    tick();
    check("rstwr_entry_kept", mem[3], ref_tbl[3]);
    tick();
    rst = 1'b0;
`ifdef BHT_CTRL_INIT_EN
    run_sweep();
`else
    sample();
    check("rstwr_init_done_low", init_done, 0);
    tick();
`endif

    // Random traffic against a transaction-level model.
    busy   = 0;
    m_last = 0;  // PRED granted last after reset
    m_addr = 0;
    m_taken = 1'b0;
    for (int c = 0; c < 600; c++) begin
      pv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      pa = $urandom_range(0, 3);
      ua = $urandom_range(0, 3);
      ut = 1'($urandom_range(0, 1));
      pred_valid = pv;
      upd_valid  = uv;
      pred_addr  = AW'(pa);
      upd_addr   = AW'(ua);
      upd_taken  = ut;
      sample();
      if (busy == 1) begin
        check("rnd_rsp", {pred_rsp_valid, pred_state, mem_wr}, {1'b1, 2'(ref_tbl[m_addr]), 1'b0});
        check("rnd_rsp_no_ready", {pred_ready, upd_ready}, 0);
        busy = 0;
      end else if (busy == 2) begin
        exp = sat(ref_tbl[m_addr], m_taken);
        check("rnd_write", {mem_wr, mem_addr, mem_wdata}, {1'b1, AW'(m_addr), 2'(exp)});
        check("rnd_wr_no_ready", {pred_ready, upd_ready}, 0);
        ref_tbl[m_addr] = exp;
        busy = 0;
      end else begin
        if (pv && uv) begin
          eg_u = (m_last == 0);
          eg_p = !eg_u;
        end else begin
          eg_u = uv;
          eg_p = pv;
        end
        check("rnd_grant", {pred_ready, upd_ready}, {eg_p, eg_u});
        check("rnd_idle_quiet", {mem_wr, pred_rsp_valid}, 0);
        if (eg_p) begin
          check("rnd_pred_addr", mem_addr, pa);
          busy = 1; m_addr = pa; m_last = 0;
        end else if (eg_u) begin
          check("rnd_upd_addr", mem_addr, ua);
          busy = 2; m_addr = ua; m_taken = ut; m_last = 1;
        end
      end
      tick();
    end
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
